// File: rtl/echo_pkg.sv
// Shared definitions for the ECHO-256 host-side word protocol.
// Holds the FSM state encoding, transfer phases and word-count constants
// common to the host controller and the core interface.
package echo_pkg;

    localparam int LEN_WORDS = 4;   // 16-bit words of the length field, MS word first
    localparam int BLK_WORDS = 96;  // 16-bit words per 1536-bit block
    localparam int DIG_WORDS = 16;  // 16-bit words of the 256-bit digest
    localparam int WIDX_W    = 7;   // word index width, covers BLK_WORDS-1
    localparam int TMR_W     = 12;  // timeout counter width

    typedef enum logic [3:0] {
        IDLE,
        LEN_ISSUE,
        MSG_REQ,
        XFER_WAIT,
        QUIET,
        BLK_RISE,
        BLK_FALL,
        FET_ISSUE,
        DONE,
        ERR
    } state_t;

    // Which kind of word the next strobe carries.
    typedef enum logic [1:0] {
        PH_LEN,
        PH_MSG,
        PH_FET
    } phase_t;

endpackage

// File: rtl/echo_host_timer.sv
// Loadable down-counter with an expiry flag, shared by the ack and busy waits.
// Ports: reload restarts the count from limit; expired is high once the count
// has run down to zero and no reload is pending in the same cycle.
module echo_host_timer #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         reload,
    input  logic [W-1:0] limit,
    output logic         expired
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (reload) begin
            cnt <= limit;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Masked on the reload cycle so a freshly entered state never times out
    // on a count left over from the previous wait.
    assign expired = !reload && (cnt == '0);

endmodule

// File: rtl/echo_host_ctrl.sv
// Host initiator for the ECHO-256 16-bit load/fetch word protocol: sends the
// length field once, streams nblocks*96 message words, then fetches 16 digest words.
// Ports: op_start/msg_len/nblocks request, in_* upstream stream, load/fetch/hdata/ack/busy/odata core side.
module echo_host_ctrl
    import echo_pkg::*;
#(
    parameter int ACK_TIMEOUT  = 255,
    parameter int BUSY_TIMEOUT = 4095
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         op_start,
    input  logic [63:0]  msg_len,
    input  logic [7:0]   nblocks,
    output logic         op_busy,
    input  logic [15:0]  in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [255:0] digest,
    output logic         digest_valid,
    output logic         err_timeout,
    output logic         load,
    output logic         fetch,
    output logic [15:0]  hdata,
    input  logic         ack,
    input  logic         busy,
    input  logic [15:0]  odata
);

    state_t              state;
    state_t              prev_state;
    phase_t              phase;
    logic [WIDX_W-1:0]   widx;
    logic [7:0]          blk_cnt;
    logic [63:0]         len_q;
    logic                tmr_reload;
    logic                tmr_expired;
    logic [TMR_W-1:0]    tmr_limit;
    logic                wait_ok;
    logic                timeout;

    assign in_ready = (state == MSG_REQ);

    // The timer restarts on every state entry; only XFER_WAIT uses the ack limit.
    assign tmr_reload = (state != prev_state);
    assign tmr_limit  = (state == XFER_WAIT) ? TMR_W'(ACK_TIMEOUT) : TMR_W'(BUSY_TIMEOUT);

    echo_host_timer #(.W(TMR_W)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .reload  (tmr_reload),
        .limit   (tmr_limit),
        .expired (tmr_expired)
    );

    // Exit condition of each waiting state; non-waiting states never time out.
    always_comb begin
        wait_ok = 1'b1;
        case (state)
            XFER_WAIT: wait_ok = ack;
            QUIET:     wait_ok = !ack && !busy;
            BLK_RISE:  wait_ok = busy;
            BLK_FALL:  wait_ok = !busy;
            default:   wait_ok = 1'b1;
        endcase
    end

    assign timeout = tmr_expired && !wait_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            prev_state   <= IDLE;
            phase        <= PH_LEN;
            widx         <= '0;
            blk_cnt      <= '0;
            len_q        <= '0;
            op_busy      <= 1'b0;
            digest       <= '0;
            digest_valid <= 1'b0;
            err_timeout  <= 1'b0;
            load         <= 1'b0;
            fetch        <= 1'b0;
            hdata        <= '0;
        end else begin
            prev_state   <= state;
            load         <= 1'b0;
            fetch        <= 1'b0;
            digest_valid <= 1'b0;

            if (timeout) begin
                state       <= ERR;
                err_timeout <= 1'b1;
                op_busy     <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (op_start && nblocks != '0) begin
                            len_q       <= msg_len;
                            blk_cnt     <= nblocks;
                            widx        <= '0;
                            phase       <= PH_LEN;
                            digest      <= '0;
                            err_timeout <= 1'b0;
                            op_busy     <= 1'b1;
                            state       <= LEN_ISSUE;
                        end
                    end
                    LEN_ISSUE: begin
                        hdata <= len_q[63 - 16*int'(widx[1:0]) -: 16];
                        load  <= 1'b1;
                        state <= XFER_WAIT;
                    end
                    MSG_REQ: begin
                        if (in_valid) begin
                            hdata <= in_data;
                            load  <= 1'b1;
                            state <= XFER_WAIT;
                        end
                    end
                    XFER_WAIT: begin
                        if (ack) begin
                            case (phase)
                                PH_LEN: begin
                                    state <= QUIET;
                                    if (widx == WIDX_W'(LEN_WORDS-1)) begin
                                        widx  <= '0;
                                        phase <= PH_MSG;
                                    end else begin
                                        widx <= widx + 1'b1;
                                    end
                                end
                                PH_MSG: begin
                                    if (widx == WIDX_W'(BLK_WORDS-1)) begin
                                        widx    <= '0;
                                        blk_cnt <= blk_cnt - 1'b1;
                                        state   <= BLK_RISE;
                                    end else begin
                                        widx  <= widx + 1'b1;
                                        state <= QUIET;
                                    end
                                end
                                default: begin
                                    digest[255 - 16*int'(widx[3:0]) -: 16] <= odata;
                                    if (widx == WIDX_W'(DIG_WORDS-1)) begin
                                        widx  <= '0;
                                        state <= DONE;
                                    end else begin
                                        widx  <= widx + 1'b1;
                                        state <= QUIET;
                                    end
                                end
                            endcase
                        end
                    end
                    QUIET: begin
                        // One quiet cycle plus one issue cycle keeps strobes two idle cycles apart.
                        if (!ack && !busy) begin
                            case (phase)
                                PH_LEN:  state <= LEN_ISSUE;
                                PH_MSG:  state <= MSG_REQ;
                                default: state <= FET_ISSUE;
                            endcase
                        end
                    end
                    BLK_RISE: begin
                        if (busy) state <= BLK_FALL;
                    end
                    BLK_FALL: begin
                        if (!busy) begin
                            if (blk_cnt != '0) begin
                                state <= MSG_REQ;
                            end else begin
                                phase <= PH_FET;
                                state <= FET_ISSUE;
                            end
                        end
                    end
                    FET_ISSUE: begin
                        fetch <= 1'b1;
                        state <= XFER_WAIT;
                    end
                    DONE: begin
                        digest_valid <= 1'b1;
                        op_busy      <= 1'b0;
                        state        <= IDLE;
                    end
                    ERR: begin
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_echo_host_ctrl.sv
// Randomised scoreboard bench for echo_host_ctrl with a behavioural ECHO core model.
// Expected load words and digests are queued at stimulus time and popped by a monitor.
// Covers reset, single/multi block, upstream stall, ack timeout, mid-fetch reset, ignored requests.
module tb_echo_host_ctrl;
    import echo_pkg::*;

    localparam int ACK_TO  = 255;
    localparam int BUSY_TO = 4095;
    localparam int MAX_CYC = 8000;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         op_start;
    logic [63:0]  msg_len;
    logic [7:0]   nblocks;
    logic         op_busy;
    logic [15:0]  in_data;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] digest;
    logic         digest_valid;
    logic         err_timeout;
    logic         load;
    logic         fetch;
    logic [15:0]  hdata;
    logic         ack;
    logic         busy;
    logic [15:0]  odata;

    always #5 clk = ~clk;

    echo_host_ctrl #(.ACK_TIMEOUT(ACK_TO), .BUSY_TIMEOUT(BUSY_TO)) dut (
        .clk(clk), .rst_n(rst_n), .op_start(op_start), .msg_len(msg_len), .nblocks(nblocks),
        .op_busy(op_busy), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .digest(digest), .digest_valid(digest_valid), .err_timeout(err_timeout),
        .load(load), .fetch(fetch), .hdata(hdata), .ack(ack), .busy(busy), .odata(odata)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [15:0]  exp_load[$];
    logic [255:0] exp_dig[$];
    int           op_loads;
    int           op_fetches;
    bit           stop_drv;

    // core model state
    logic [15:0]  rx[$];
    int           m_loads = 0;
    int           m_fetches = 0;
    int           ack_wait = -1;
    int           busy_wait = -1;
    int           busy_left = 0;
    int           busy_len = 10;
    int           withhold_n = 0;
    bit           pend_fetch = 1'b0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Stand-in for the core's hash: any order-sensitive mix of every loaded word.
    function automatic logic [15:0] hash_word(input logic [15:0] ws[$], input int k);
        logic [31:0] h;
        h = 32'h0001_5a5a + 32'(k) * 32'd977;
        foreach (ws[i]) h = (h * 32'd33) ^ (32'(ws[i]) + 32'(k));
        return h[31:16] ^ h[15:0];
    endfunction

    function automatic logic [255:0] ref_digest(input logic [15:0] ws[$]);
        logic [255:0] d;
        d = '0;
        for (int k = 0; k < DIG_WORDS; k++) d[255 - 16*k -: 16] = hash_word(ws, k);
        return d;
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_load"},         256'(load), 0);
        check({tag, "_fetch"},        256'(fetch), 0);
        check({tag, "_hdata"},        256'(hdata), 0);
        check({tag, "_in_ready"},     256'(in_ready), 0);
        check({tag, "_op_busy"},      256'(op_busy), 0);
        check({tag, "_digest"},       digest, 0);
        check({tag, "_digest_valid"}, 256'(digest_valid), 0);
        check({tag, "_err_timeout"},  256'(err_timeout), 0);
    endtask

    // Core model: ack 0..2 cycles after each strobe, busy pulse after every 96th message word.
    initial begin
        ack = 1'b0; busy = 1'b0; odata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                ack = 1'b0; busy = 1'b0; ack_wait = -1; busy_wait = -1; busy_left = 0;
            end else begin
                ack = 1'b0;
                if (load || fetch) begin
                    pend_fetch = fetch;
                    if (load) begin
                        m_loads++;
                        rx.push_back(hdata);
                    end
                    if (!(load && m_loads == withhold_n)) ack_wait = int'($urandom_range(0, 2));
                end
                if (ack_wait == 0) begin
                    ack = 1'b1;
                    ack_wait = -1;
                    if (pend_fetch) begin
                        odata = hash_word(rx, m_fetches);
                        m_fetches++;
                    end else if (m_loads > LEN_WORDS && (m_loads - LEN_WORDS) % BLK_WORDS == 0) begin
                        busy_wait = int'($urandom_range(1, 3));
                    end
                end else if (ack_wait > 0) begin
                    ack_wait--;
                end
                if (busy_wait == 0) begin
                    busy = 1'b1; busy_left = busy_len; busy_wait = -1;
                end else if (busy_wait > 0) begin
                    busy_wait--;
                end else if (busy) begin
                    busy_left--;
                    if (busy_left <= 0) busy = 1'b0;
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a load or a digest.
    always @(negedge clk) begin
        logic [15:0] e;
        if (rst_n) begin
            if (load) begin
                op_loads++;
                if (exp_load.size() == 0) begin
                    check("unexpected_load", 256'(hdata), 256'(17'h10000));
                end else begin
                    e = exp_load.pop_front();
                    check("load_hdata", 256'(hdata), 256'(e));
                end
            end
            if (fetch) op_fetches++;
            if (load || fetch) begin
                check("strobe_exclusive", 256'(load & fetch), 0);
                check("strobe_while_busy", 256'(busy), 0);
            end
            if (digest_valid) begin
                if (exp_dig.size() == 0) begin
                    check("unexpected_digest_valid", 256'(digest_valid), 0);
                end else begin
                    check("digest", digest, exp_dig.pop_front());
                end
                check("op_busy_with_digest_valid", 256'(op_busy), 0);
            end
        end
    end

    task automatic drive_stream(input logic [15:0] ws[$], input int stall_at);
        foreach (ws[i]) begin
            if (stop_drv) break;
            if (i == stall_at) begin
                in_valid = 1'b0;
                for (int c = 0; c < 10; c++) begin
                    @(negedge clk);
                    check("no_load_in_stall", 256'(load), 0);
                end
            end else if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = ws[i];
            while (!in_ready && !stop_drv) @(negedge clk);
            if (stop_drv) break;
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic run_op(input logic [63:0] len, input int nb, input int stall_at,
                          input int withhold, input bit rst_fetch, input bit extra, input int blen);
        logic [15:0] words[$];
        logic [15:0] all[$];
        int n_exp, n, lc, fc, n_w;
        bit rst_hit, done_ok;
        for (int i = 0; i < nb * BLK_WORDS; i++) words.push_back(16'($urandom));
        all.push_back(len[63:48]);
        all.push_back(len[47:32]);
        all.push_back(len[31:16]);
        all.push_back(len[15:0]);
        foreach (words[i]) all.push_back(words[i]);
        n_exp = (withhold > 0) ? withhold : all.size();
        exp_load.delete();
        for (int i = 0; i < n_exp; i++) exp_load.push_back(all[i]);
        if (withhold == 0 && !rst_fetch) exp_dig.push_back(ref_digest(all));
        rx.delete();
        m_loads = 0; m_fetches = 0; withhold_n = withhold; busy_len = blen;
        op_loads = 0; op_fetches = 0; stop_drv = 1'b0;
        n = 0; lc = 0; fc = 0; n_w = -1; rst_hit = 1'b0;

        op_start = 1'b1; msg_len = len; nblocks = 8'(nb);
        @(negedge clk);
        op_start = 1'b0;
        check("op_busy_after_start", 256'(op_busy), 1);
        check("err_timeout_after_start", 256'(err_timeout), 0);

        fork
            drive_stream(words, stall_at);
            begin
                while (!digest_valid && !err_timeout && n < MAX_CYC) begin
                    @(negedge clk);
                    n++;
                    if (extra && n == 150) begin
                        op_start = 1'b1; nblocks = 8'd3; msg_len = {$urandom, $urandom};
                    end else begin
                        op_start = 1'b0;
                    end
                    if (load) begin
                        lc++;
                        if (lc == withhold) n_w = n;
                    end
                    if (fetch) fc++;
                    if (rst_fetch && fc == 7) begin
                        rst_n = 1'b0;
                        #1;
                        check_zero("reset_mid_fetch");
                        rst_hit = 1'b1;
                        break;
                    end
                end
                done_ok = digest_valid || err_timeout || rst_hit;
                check("op_finished_in_budget", 256'(done_ok), 1);
                stop_drv = 1'b1;
            end
        join
        op_start = 1'b0;

        if (withhold > 0) begin
            check("err_timeout_set", 256'(err_timeout), 1);
            check("ack_timeout_delay", 256'(n_w >= 0 && (n - n_w) >= ACK_TO && (n - n_w) <= ACK_TO + 5), 1);
            check("op_busy_after_err", 256'(op_busy), 0);
            repeat (50) @(negedge clk);
            check("loads_after_err", 256'(op_loads), 256'(withhold));
            check("fetches_after_err", 256'(op_fetches), 0);
            check("err_timeout_sticky", 256'(err_timeout), 1);
        end else if (rst_fetch) begin
            check("loads_before_reset", 256'(lc), 256'(n_exp));
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
            exp_load.delete();
            exp_dig.delete();
            @(negedge clk);
        end else begin
            check("err_timeout_clear", 256'(err_timeout), 0);
            repeat (4) @(negedge clk);
            check("total_loads", 256'(op_loads), 256'(LEN_WORDS + nb * BLK_WORDS));
            check("total_fetches", 256'(op_fetches), 256'(DIG_WORDS));
            check("loads_outstanding", 256'(exp_load.size()), 0);
            check("digest_outstanding", 256'(exp_dig.size()), 0);
            check("op_busy_idle", 256'(op_busy), 0);
        end
    endtask

    initial begin
        rst_n = 1'b0; op_start = 1'b0; msg_len = '0; nblocks = '0;
        in_valid = 1'b0; in_data = '0; stop_drv = 1'b0; op_loads = 0; op_fetches = 0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // nblocks == 0 must be ignored entirely
        op_start = 1'b1; msg_len = 64'h600; nblocks = 8'd0;
        @(negedge clk);
        op_start = 1'b0;
        repeat (20) @(negedge clk);
        check("zero_blocks_op_busy", 256'(op_busy), 0);
        check("zero_blocks_loads", 256'(op_loads), 0);
        check("zero_blocks_fetches", 256'(op_fetches), 0);

        run_op(64'h600, 1, -1, 0, 1'b0, 1'b0, 10);
        run_op(64'h600, 1, 40, 0, 1'b0, 1'b0, 10);
        run_op({$urandom, $urandom}, 2, -1, 0, 1'b0, 1'b1, 50);
        run_op({$urandom, $urandom}, 1, -1, 6, 1'b0, 1'b0, 10);
        run_op({$urandom, $urandom}, 1, -1, 0, 1'b0, 1'b0, 20);
        run_op({$urandom, $urandom}, 1, -1, 0, 1'b1, 1'b0, 5);
        run_op({$urandom, $urandom}, 1, -1, 0, 1'b0, 1'b0, 5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/echo_host_ctrl.md
Name: echo_host_ctrl

Overview:
- Host-side initiator for the ECHO-256 core's 16-bit load/fetch word protocol.
- Takes an operation request (64-bit message length, block count) plus an upstream 16-bit message word stream.
- Drives load/fetch with data words, tracks ack/busy, and reassembles the 256-bit digest from 16 fetched words.
- Sits between the SoC/testbench datapath and the ECHO core interface.

Parameters:
- LEN_WORDS, 4: 16-bit words of length field, most significant word first.
- BLK_WORDS, 96: 16-bit words per 1536-bit message block.
- DIG_WORDS, 16: 16-bit words of digest.
- ACK_TIMEOUT, 255: maximum cycles waiting for ack after load/fetch.
- BUSY_TIMEOUT, 4095: maximum cycles waiting for busy rise or fall around a block compression.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- op_start, input, 1: one-cycle request; samples msg_len and nblocks.
- msg_len, input, 64: message length in bits, sent as the length field.
- nblocks, input, 8: number of 96-word blocks to send.
- op_busy, output, 1: high from accepted op_start until done or error.
- in_data, input, 16: upstream message word.
- in_valid, input, 1: in_data valid.
- in_ready, output, 1: word accepted when in_valid && in_ready.
- digest, output, 256: assembled hash; word 0 lands in [255:240].
- digest_valid, output, 1: one-cycle pulse when digest is complete.
- err_timeout, output, 1: sticky timeout flag; cleared by the next accepted op_start.
- load, output, 1: one-cycle load strobe to the core.
- fetch, output, 1: one-cycle fetch strobe to the core.
- hdata, output, 16: word presented to the core; held from the load cycle until ack is seen.
- ack, input, 1: core acknowledge.
- busy, input, 1: core compression in progress.
- odata, input, 16: digest word from the core; valid when ack is high after a fetch.

Behaviour:
- Reset values:
  - all outputs 0: load, fetch, hdata, in_ready, op_busy, digest, digest_valid, err_timeout.
  - internal counters 0; FSM in IDLE.
- Reset mid-operation aborts immediately. No further strobes are issued. The core is resynchronised by its own reset.
- FSM states: IDLE, LEN_ISSUE, MSG_REQ, XFER_WAIT, QUIET, BLK_RISE, BLK_FALL, FET_ISSUE, DONE, ERR.
- IDLE:
  - op_start with nblocks != 0: latch msg_len and nblocks, clear err_timeout, set op_busy, go to LEN_ISSUE.
  - op_start with nblocks == 0 is ignored. op_start while op_busy is ignored.
- LEN_ISSUE: hdata <= msg_len word[widx] (MS word first), load=1 for exactly one cycle, go to XFER_WAIT.
- MSG_REQ: in_ready=1 (combinational, this state only). On transfer, hdata <= in_data and load=1 next cycle, then XFER_WAIT.
- XFER_WAIT: wait for ack==1 (ACK_TIMEOUT counter). Then:
  - if the transfer was the last word of a block, go to BLK_RISE;
  - otherwise go to QUIET.
- QUIET:
  - wait until ack==0 && busy==0; minimum one cycle in QUIET.
  - next state is LEN_ISSUE, MSG_REQ or FET_ISSUE per phase and word counters.
  - at least 2 idle cycles separate consecutive strobes.
- BLK_RISE: wait busy==1 (BUSY_TIMEOUT), then BLK_FALL.
- BLK_FALL: wait busy==0 (BUSY_TIMEOUT). Then:
  - if blocks remain: widx=0, go to MSG_REQ;
  - otherwise go to FET_ISSUE.
- FET_ISSUE: fetch=1 for one cycle, then XFER_WAIT. In the cycle ack is seen, capture odata into digest[255-16*k -: 16], k = fetch index.
- After DIG_WORDS fetches, go to DONE. DONE: digest_valid=1 for one cycle, op_busy <= 0, go to IDLE. digest holds until the next accepted op_start.
- Transaction totals per operation:
  - LEN_WORDS + nblocks*BLK_WORDS loads;
  - DIG_WORDS fetches;
  - length is sent only once per operation.
- load and fetch are never asserted together and never asserted while busy==1.
- Timeouts:
  - the counter clears on each state entry;
  - when it reaches its limit, go to ERR: err_timeout=1, op_busy=0, strobes 0, back to IDLE next cycle.
- Counters:
  - word index 7 bits, wraps to 0 at the phase end;
  - block counter 8 bits, counts down;
  - timeout counter 12 bits.

Decomposition:
- Shared package echo_pkg holds:
  - FSM state enum;
  - LEN_WORDS, BLK_WORDS, DIG_WORDS constants (shared with the core interface);
  - word-index width.
- One sub-module: echo_host_timer (loadable down-counter with expiry flag), used for both ack and busy waits.

Test Plan:
- Single block: msg_len=0x600, nblocks=1, core model.
  - Expect 100 loads: hdata 0x0000, 0x0000, 0x0000, 0x0600, then 96 stream words in order.
  - Then 16 fetches; digest equals the model's 256-bit value; one digest_valid pulse; op_busy falls with it.
- Upstream stall: in_valid low for 10 cycles before word 40 -> no load during the gap; word order intact; final digest unchanged.
- Two blocks: nblocks=2, model busy=1 for 50 cycles after each block -> no load/fetch while busy; 196 loads total; length sent once.
- Ack timeout: model withholds ack on load 6 -> err_timeout=1 after ACK_TIMEOUT cycles; op_busy=0; no further strobes; next op_start clears err_timeout and completes.
- Reset mid-fetch: rst_n low during fetch 7 -> all outputs 0 immediately; a fresh operation after reset yields the correct digest.
- Ignored requests: op_start with nblocks=0 -> no strobes, op_busy stays 0; op_start pulsed during an active operation -> no effect on the transfer count.
